// File: rtl/video_pkg.sv
// Shared video timing types and defaults for the raster path.
package video_pkg;

  typedef enum logic [1:0] {Active, Front, Sync, Back} phase_e;

  localparam int unsigned WidthDef   = 100;
  localparam int unsigned HeightDef  = 72;
  localparam int unsigned CellPxDef  = 8;
  localparam int unsigned HActiveDef = 800;
  localparam int unsigned HFrontDef  = 40;
  localparam int unsigned HSyncDef   = 128;
  localparam int unsigned HBackDef   = 88;
  localparam int unsigned VActiveDef = 600;
  localparam int unsigned VFrontDef  = 1;
  localparam int unsigned VSyncDef   = 4;
  localparam int unsigned VBackDef   = 23;

  function automatic int unsigned axis_total(int unsigned active, int unsigned front,
                                             int unsigned sync, int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned h_total(int unsigned active, int unsigned front,
                                          int unsigned sync, int unsigned back);
    return axis_total(active, front, sync, back);
  endfunction

  function automatic int unsigned v_total(int unsigned active, int unsigned front,
                                          int unsigned sync, int unsigned back);
    return axis_total(active, front, sync, back);
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: position counter, phase FSM, sync level and cell sub-counter.
module sync_axis_counter
  import video_pkg::*;
#(
  parameter int unsigned active_p   = 800,
  parameter int unsigned front_p    = 40,
  parameter int unsigned sync_p     = 128,
  parameter int unsigned back_p     = 88,
  parameter int unsigned cells_p    = 100,
  parameter int unsigned cell_px_p  = 8,
  parameter bit          sync_pol_p = 1'b1,
  parameter int unsigned pos_w_p    = 11,
  parameter int unsigned cell_w_p   = 7
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                step_i,
  input  logic [pos_w_p-1:0]  total_i,
  output logic [pos_w_p-1:0]  pos_o,
  output phase_e              phase_o,
  output logic                wrap_o,
  output logic                sync_o,
  output logic [cell_w_p-1:0] cell_o,
  output logic                in_grid_o
);

  localparam int unsigned PxW    = (cell_px_p > 1) ? $clog2(cell_px_p) : 1;
  localparam int unsigned GridPx = cells_p * cell_px_p;

  localparam logic [pos_w_p-1:0]  ActLast   = pos_w_p'(active_p - 1);
  localparam logic [pos_w_p-1:0]  FrontLast = pos_w_p'(active_p + front_p - 1);
  localparam logic [pos_w_p-1:0]  SyncLast  = pos_w_p'(active_p + front_p + sync_p - 1);
  localparam logic [PxW-1:0]      PxLast    = PxW'(cell_px_p - 1);
  localparam logic [cell_w_p-1:0] CellLast  = cell_w_p'(cells_p - 1);

  logic [pos_w_p-1:0]  pos_q, pos_d;
  logic [PxW-1:0]      px_q, px_d;
  logic [cell_w_p-1:0] cell_q, cell_d;
  phase_e              phase_q, phase_d;
  logic                wrap;

  assign wrap = (pos_q == total_i - pos_w_p'(1));

  always_comb begin
    phase_d = phase_q;
    if (step_i) begin
      unique case (phase_q)
        Active:  if (pos_q == ActLast)   phase_d = Front;
        Front:   if (pos_q == FrontLast) phase_d = Sync;
        Sync:    if (pos_q == SyncLast)  phase_d = Back;
        Back:    if (wrap)               phase_d = Active;
        default:                         phase_d = Active;
      endcase
    end
  end

  // The cell index saturates past the grid edge and only restarts at position 0.
  always_comb begin
    pos_d  = pos_q;
    px_d   = px_q;
    cell_d = cell_q;
    if (step_i) begin
      if (wrap) begin
        pos_d  = '0;
        px_d   = '0;
        cell_d = '0;
      end else begin
        pos_d = pos_q + pos_w_p'(1);
        if (px_q == PxLast) begin
          px_d = '0;
          if (cell_q != CellLast) cell_d = cell_q + cell_w_p'(1);
        end else begin
          px_d = px_q + PxW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pos_q   <= '0;
      px_q    <= '0;
      cell_q  <= '0;
      phase_q <= Active;
    end else begin
      pos_q   <= pos_d;
      px_q    <= px_d;
      cell_q  <= cell_d;
      phase_q <= phase_d;
    end
  end

  assign pos_o     = pos_q;
  assign phase_o   = phase_q;
  assign wrap_o    = wrap;
  assign cell_o    = cell_q;
  assign sync_o    = (phase_q == Sync) ? sync_pol_p : ~sync_pol_p;
  assign in_grid_o = (phase_q == Active) && (32'(pos_q) < GridPx);

endmodule

// File: rtl/raster_scanner.sv
// Raster timing generator: walks the cell grid and registers colour and sync to the VGA pins.
module raster_scanner
  import video_pkg::*;
#(
  parameter int unsigned width_p    = WidthDef,
  parameter int unsigned height_p   = HeightDef,
  parameter int unsigned cell_px_p  = CellPxDef,
  parameter int unsigned h_active_p = HActiveDef,
  parameter int unsigned h_front_p  = HFrontDef,
  parameter int unsigned h_sync_p   = HSyncDef,
  parameter int unsigned h_back_p   = HBackDef,
  parameter int unsigned v_active_p = VActiveDef,
  parameter int unsigned v_front_p  = VFrontDef,
  parameter int unsigned v_sync_p   = VSyncDef,
  parameter int unsigned v_back_p   = VBackDef,
  parameter bit          sync_pol_p = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,
  output logic [$clog2(width_p)-1:0]  x_o,
  output logic [$clog2(height_p)-1:0] y_o,
  output logic                        coord_v_o,
  input  logic                        r_i,
  input  logic                        g_i,
  input  logic                        b_i,
  output logic                        r_o,
  output logic                        g_o,
  output logic                        b_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        frame_o
);

  localparam int unsigned HTotal = h_total(h_active_p, h_front_p, h_sync_p, h_back_p);
  localparam int unsigned VTotal = v_total(v_active_p, v_front_p, v_sync_p, v_back_p);
  // One extra value so a power-of-two total still fits in total_i.
  localparam int unsigned HPosW  = $clog2(HTotal + 1);
  localparam int unsigned VPosW  = $clog2(VTotal + 1);
  localparam int unsigned XW     = $clog2(width_p);
  localparam int unsigned YW     = $clog2(height_p);

  logic [HPosW-1:0] h_pos;
  logic [VPosW-1:0] v_pos;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic [XW-1:0]    h_cell;
  logic [YW-1:0]    v_cell;
  logic             h_in_grid, v_in_grid;
  logic             v_step;
  logic             coord_d, frame_d;
  logic             hsync_q, vsync_q;
  logic             unused_v_wrap;

  assign v_step        = en_i & h_wrap;
  assign unused_v_wrap = v_wrap;

  sync_axis_counter #(
    .active_p   (h_active_p),
    .front_p    (h_front_p),
    .sync_p     (h_sync_p),
    .back_p     (h_back_p),
    .cells_p    (width_p),
    .cell_px_p  (cell_px_p),
    .sync_pol_p (sync_pol_p),
    .pos_w_p    (HPosW),
    .cell_w_p   (XW)
  ) u_h_axis (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .step_i    (en_i),
    .total_i   (HPosW'(HTotal)),
    .pos_o     (h_pos),
    .phase_o   (h_phase),
    .wrap_o    (h_wrap),
    .sync_o    (h_sync),
    .cell_o    (h_cell),
    .in_grid_o (h_in_grid)
  );

  sync_axis_counter #(
    .active_p   (v_active_p),
    .front_p    (v_front_p),
    .sync_p     (v_sync_p),
    .back_p     (v_back_p),
    .cells_p    (height_p),
    .cell_px_p  (cell_px_p),
    .sync_pol_p (sync_pol_p),
    .pos_w_p    (VPosW),
    .cell_w_p   (YW)
  ) u_v_axis (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .step_i    (v_step),
    .total_i   (VPosW'(VTotal)),
    .pos_o     (v_pos),
    .phase_o   (v_phase),
    .wrap_o    (v_wrap),
    .sync_o    (v_sync),
    .cell_o    (v_cell),
    .in_grid_o (v_in_grid)
  );

  assign coord_d = (h_phase == Active) && (v_phase == Active) && h_in_grid && v_in_grid;
  assign frame_d = (h_pos == '0) && (v_pos == VPosW'(v_active_p));

  // Stage 1 presents the coordinate to the lookup; stage 2 captures colour with the delayed syncs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_o       <= '0;
      y_o       <= '0;
      coord_v_o <= 1'b0;
      frame_o   <= 1'b0;
      hsync_q   <= ~sync_pol_p;
      vsync_q   <= ~sync_pol_p;
      r_o       <= 1'b0;
      g_o       <= 1'b0;
      b_o       <= 1'b0;
      hsync_o   <= ~sync_pol_p;
      vsync_o   <= ~sync_pol_p;
    end else if (en_i) begin
      x_o       <= h_cell;
      y_o       <= v_cell;
      coord_v_o <= coord_d;
      frame_o   <= frame_d;
      hsync_q   <= h_sync;
      vsync_q   <= v_sync;
      r_o       <= coord_v_o & r_i;
      g_o       <= coord_v_o & g_i;
      b_o       <= coord_v_o & b_i;
      hsync_o   <= hsync_q;
      vsync_o   <= vsync_q;
    end
  end

endmodule

// File: tb/tb_raster_scanner.sv
// Directed bench for raster_scanner on a reduced timing so whole frames fit in a short run.
module tb_raster_scanner;

  localparam int HT    = 21;  // 14 + 2 + 3 + 2
  localparam int VT    = 16;  // 11 + 1 + 2 + 2
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       en_i;
  logic [1:0] x_o;
  logic [1:0] y_o;
  logic       coord_v_o;
  logic       r_i, g_i, b_i;
  logic       r_o, g_o, b_o;
  logic       hsync_o, vsync_o, frame_o;
  logic       r_force;
  logic [10:0] act;

  int errors = 0;
  int checks = 0;
  int k;

  always #5 clk = ~clk;

  assign r_i = r_force | (x_o == 2'd1 && y_o == 2'd1);
  assign g_i = x_o[0];
  assign b_i = y_o[0];
  assign act = {x_o, y_o, coord_v_o, frame_o, hsync_o, vsync_o, r_o, g_o, b_o};

  raster_scanner #(
    .width_p    (4),
    .height_p   (3),
    .cell_px_p  (3),
    .h_active_p (14),
    .h_front_p  (2),
    .h_sync_p   (3),
    .h_back_p   (2),
    .v_active_p (11),
    .v_front_p  (1),
    .v_sync_p   (2),
    .v_back_p   (2),
    .sync_pol_p (1'b1)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .x_o       (x_o),
    .y_o       (y_o),
    .coord_v_o (coord_v_o),
    .r_i       (r_i),
    .g_i       (g_i),
    .b_i       (b_i),
    .r_o       (r_o),
    .g_o       (g_o),
    .b_o       (b_o),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .frame_o   (frame_o)
  );

  function automatic int cell_x(int h);
    return (h / 3 > 3) ? 3 : h / 3;
  endfunction

  function automatic int cell_y(int v);
    return (v / 3 > 2) ? 2 : v / 3;
  endfunction

  // Expected pins after k enabled edges since reset release.
  function automatic logic [10:0] exp_pins(int kk, logic frc);
    int h1, v1, h2, v2;
    logic [1:0] x1, y1, x2, y2;
    logic c1, fr, c2, hs, vs, r, g, b;
    x1 = '0; y1 = '0; c1 = 0; fr = 0; hs = 0; vs = 0; r = 0; g = 0; b = 0;
    if (kk >= 1) begin
      h1 = (kk - 1) % HT;
      v1 = ((kk - 1) / HT) % VT;
      x1 = 2'(cell_x(h1));
      y1 = 2'(cell_y(v1));
      c1 = (h1 < 12) && (v1 < 9);
      fr = (h1 == 0) && (v1 == 11);
    end
    if (kk >= 2) begin
      h2 = (kk - 2) % HT;
      v2 = ((kk - 2) / HT) % VT;
      x2 = 2'(cell_x(h2));
      y2 = 2'(cell_y(v2));
      c2 = (h2 < 12) && (v2 < 9);
      hs = (h2 >= 16) && (h2 <= 18);
      vs = (v2 >= 12) && (v2 <= 13);
      r  = c2 && (frc || (x2 == 2'd1 && y2 == 2'd1));
      g  = c2 && x2[0];
      b  = c2 && y2[0];
    end
    return {x1, y1, c1, fr, hs, vs, r, g, b};
  endfunction

  task automatic restart();
    en_i    = 1'b1;
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    r_force = 1'b0;
    en_i    = 1'b1;
    reset_i = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      e = exp_pins(0, r_force);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL reset_hold got=%b exp=%b", act, e);
      end
    end
    reset_i = 1'b0;
    k = 0;
  endtask

  task automatic test_full_frame();
    logic [10:0] e;
    int frames;
    frames = 0;
    restart();
    repeat (2 * FRAME + 4) begin
      @(posedge clk);
      #1 k++;
      e = exp_pins(k, r_force);
      if (frame_o === 1'b1) frames++;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL full_frame k=%0d got=%b exp=%b", k, act, e);
      end
    end
    checks++;
    if (frames !== 2) begin
      errors++;
      $display("FAIL frame_pulse_count got=%0d exp=2", frames);
    end
  endtask

  task automatic test_blank_colour();
    logic [10:0] e;
    r_force = 1'b1;
    restart();
    repeat (FRAME + 2) begin
      @(posedge clk);
      #1 k++;
      e = exp_pins(k, r_force);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL blank_colour k=%0d got=%b exp=%b", k, act, e);
      end
    end
    r_force = 1'b0;
  endtask

  task automatic test_half_rate();
    logic [10:0] e;
    restart();
    en_i = 1'b0;
    repeat (2 * (FRAME + 4)) begin
      @(posedge clk);
      #1;
      if (en_i) k++;
      e = exp_pins(k, r_force);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL half_rate k=%0d en=%b got=%b exp=%b", k, en_i, act, e);
      end
      en_i = ~en_i;
    end
    en_i = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    restart();
    // Stop with h=7, v=5 on the stage-1 outputs.
    repeat (5 * HT + 8) begin
      @(posedge clk);
      #1 k++;
    end
    e = exp_pins(k, r_force);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL async_pre k=%0d got=%b exp=%b", k, act, e);
    end
    #2 reset_i = 1'b1;
    #1;
    e = exp_pins(0, r_force);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL async_immediate got=%b exp=%b", act, e);
    end
    @(posedge clk);
    #1 reset_i = 1'b0;
    k = 0;
    repeat (2 * HT + 3) begin
      @(posedge clk);
      #1 k++;
      e = exp_pins(k, r_force);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL async_restart k=%0d got=%b exp=%b", k, act, e);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    en_i    = 1'b1;
    r_force = 1'b0;
    k       = 0;
    test_reset();
    test_full_frame();
    test_blank_colour();
    test_half_rate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
